mdu_sequencer: RTL

//  Multi-cycle MULT/DIV controller (HI/LO unit) in the EX stage. It borrows the shared ALU and runs NBITS

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_sequencer_if.sv | 39 +++
 rtl/mdu_iter_step.sv | 62 ++++++
 rtl/mdu_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
// Holds the MDU op codes, the shared-ALU opcode constants and the FSM state encoding,
// plus small helpers that classify an op code.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  // Must match the EX-stage ALU opcode encoding.
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: request, HI/LO access and shared-ALU signals of the MDU sequencer.
// Ports: i_start/i_op/i_rs/i_rt (op request), i_hi_we/i_lo_we/i_wdata (MTHI/MTLO),
//   i_alu_result and o_alu_* (borrowed ALU), o_ready/o_done/o_hi/o_lo (status and results).
// slave = the sequencer, master = the pipeline/ALU side.
interface mdu_sequencer_if #(
  parameter int NBITS = 32,
  parameter int NB_OP = 4
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [NBITS-1:0] i_rs;
  logic [NBITS-1:0] i_rt;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [NBITS-1:0] i_wdata;
  logic [NBITS-1:0] i_alu_result;
  logic             o_alu_sel;
  logic [NBITS-1:0] o_alu_data_1;
  logic [NBITS-1:0] o_alu_data_2;
  logic [NB_OP-1:0] o_alu_operation;
  logic             o_alu_ushamt;
  logic [4:0]       o_alu_shamt;
  logic             o_ready;
  logic             o_done;
  logic [NBITS-1:0] o_hi;
  logic [NBITS-1:0] o_lo;

  modport slave (
    input  i_start, i_op, i_rs, i_rt, i_hi_we, i_lo_we, i_wdata, i_alu_result,
    output o_alu_sel, o_alu_data_1, o_alu_data_2, o_alu_operation, o_alu_ushamt,
           o_alu_shamt, o_ready, o_done, o_hi, o_lo
  );

  modport master (
    output i_start, i_op, i_rs, i_rt, i_hi_we, i_lo_we, i_wdata, i_alu_result,
    input  o_alu_sel, o_alu_data_1, o_alu_data_2, o_alu_operation, o_alu_ushamt,
           o_alu_shamt, o_ready, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: combinational single iteration of shift-add multiply / restoring divide.
// Ports: i_div selects divide; i_hi/i_lo = working {P} or {R,Q}; i_m = multiplicand or divisor;
//   i_alu_result from the shared ALU; o_alu_* = operands/opcode to request; o_hi/o_lo = next working state.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NB_OP = 4
) (
  input  logic             i_div,
  input  logic [NBITS-1:0] i_hi,
  input  logic [NBITS-1:0] i_lo,
  input  logic [NBITS-1:0] i_m,
  input  logic [NBITS-1:0] i_alu_result,
  output logic [NBITS-1:0] o_alu_a,
  output logic [NBITS-1:0] o_alu_b,
  output logic [NB_OP-1:0] o_alu_op,
  output logic [NBITS-1:0] o_hi,
  output logic [NBITS-1:0] o_lo
);

  logic [NBITS-1:0] r_shift;
  logic             carry;
  logic             borrow;

  // Remainder shifted left, pulling in the next dividend bit from the top of Q.
  assign r_shift = {i_hi[NBITS-2:0], i_lo[NBITS-1]};

  // Operand selection kept apart from the result path so there is no combinational
  // feedback through the external ALU.
  assign o_alu_a  = i_div ? r_shift : i_hi;
  assign o_alu_b  = i_m;
  assign o_alu_op = i_div ? NB_OP'(ALU_SUB) : NB_OP'(ALU_ADD);

  // The ALU is NBITS wide, so the 33rd bit of add/subtract is recovered locally.
  assign carry  = i_alu_result < i_hi;
  assign borrow = r_shift < i_m;

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_div) begin
      // The bit shifted out of R (i_hi msb) makes the true remainder >= 2^NBITS > D.
      if (i_hi[NBITS-1] | ~borrow) begin
        o_hi = i_alu_result;
        o_lo = {i_lo[NBITS-2:0], 1'b1};
      end else begin
        o_hi = r_shift;
        o_lo = {i_lo[NBITS-2:0], 1'b0};
      end
    end else begin
      if (i_lo[0]) begin
        o_hi = {carry, i_alu_result[NBITS-1:1]};
        o_lo = {i_alu_result[0], i_lo[NBITS-1:1]};
      end else begin
        o_hi = {1'b0, i_hi[NBITS-1:1]};
        o_lo = {i_hi[0], i_lo[NBITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/DIV (HI/LO unit) that borrows the EX ALU for NBITS iterations.
// Ports: i_clk, i_reset (async, active-high); bus (mdu_sequencer_if.slave): op request, MTHI/MTLO,
//   shared-ALU operands/result, o_ready/o_done, o_hi/o_lo.
// Optional macro SIGNED_MDU_EN: signed MULT/DIV via magnitude setup and an ALU-driven FIX state.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NB_OP = 4,
  parameter int CNTB  = 6
) (
  input logic            i_clk,
  input logic            i_reset,
  mdu_sequencer_if.slave bus
);

  localparam logic [CNTB-1:0] LAST = CNTB'(NBITS - 1);

  mdu_state_e       state, state_nxt;
  logic [CNTB-1:0]  cnt;
  logic [NBITS-1:0] w_hi, w_lo, w_m;     // working {P} or {R,Q}, and M/D
  logic [NBITS-1:0] hi_q, lo_q;          // architectural HI/LO
  logic             is_div_q;
  logic             use_fix;
  logic [NBITS-1:0] rs_mag, rt_mag;
  logic [NBITS-1:0] step_a, step_b, step_hi, step_lo;
  logic [NB_OP-1:0] step_op;
  logic [NBITS-1:0] alu_a, alu_b;
  logic [NB_OP-1:0] alu_op;
  logic             req_div;

  assign req_div = op_is_div(bus.i_op);

`ifdef SIGNED_MDU_EN
  logic sgn_q, neg_q, neg_rem_q, fix_step_q, borrow_q;
  logic req_sgn;

  assign req_sgn = op_is_signed(bus.i_op);
  assign rs_mag  = (req_sgn && bus.i_rs[NBITS-1]) ? -bus.i_rs : bus.i_rs;
  assign rt_mag  = (req_sgn && bus.i_rt[NBITS-1]) ? -bus.i_rt : bus.i_rt;
  assign use_fix = sgn_q;
`else
  assign rs_mag  = bus.i_rs;
  assign rt_mag  = bus.i_rt;
  assign use_fix = 1'b0;
`endif

  mdu_iter_step #(
    .NBITS(NBITS),
    .NB_OP(NB_OP)
  ) u_step (
    .i_div       (is_div_q),
    .i_hi        (w_hi),
    .i_lo        (w_lo),
    .i_m         (w_m),
    .i_alu_result(bus.i_alu_result),
    .o_alu_a     (step_a),
    .o_alu_b     (step_b),
    .o_alu_op    (step_op),
    .o_hi        (step_hi),
    .o_lo        (step_lo)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = NB_OP'(ALU_ADD);
    case (state)
      ST_IDLE: if (bus.i_start) state_nxt = ST_RUN;
      ST_RUN: begin
        alu_a  = step_a;
        alu_b  = step_b;
        alu_op = step_op;
        if (cnt == LAST) state_nxt = use_fix ? ST_FIX : ST_DONE;
      end
      ST_FIX: begin
`ifdef SIGNED_MDU_EN
        // Negate as 0 - x. The high product word subtracts the LO borrow by using
        // all-ones (= -1) as the minuend instead of zero.
        alu_op = NB_OP'(ALU_SUB);
        if (!is_div_q && fix_step_q) begin
          alu_a     = {NBITS{borrow_q}};
          alu_b     = w_hi;
          state_nxt = ST_DONE;
        end else begin
          alu_b = w_lo;
          if (is_div_q) state_nxt = ST_DONE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt        <= '0;
      w_hi       <= '0;
      w_lo       <= '0;
      w_m        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
`ifdef SIGNED_MDU_EN
      sgn_q      <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      fix_step_q <= 1'b0;
      borrow_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            // A start in the same cycle as MTHI/MTLO wins; the write is dropped.
            is_div_q <= req_div;
            cnt      <= '0;
            w_hi     <= '0;
            w_lo     <= req_div ? rs_mag : rt_mag;
            w_m      <= req_div ? rt_mag : rs_mag;
`ifdef SIGNED_MDU_EN
            sgn_q      <= req_sgn;
            neg_q      <= req_sgn & (bus.i_rs[NBITS-1] ^ bus.i_rt[NBITS-1]);
            neg_rem_q  <= req_sgn & bus.i_rs[NBITS-1];
            fix_step_q <= 1'b0;
            borrow_q   <= 1'b0;
`endif
          end else begin
            if (bus.i_hi_we) hi_q <= bus.i_wdata;
            if (bus.i_lo_we) lo_q <= bus.i_wdata;
          end
        end
        ST_RUN: begin
          w_hi <= step_hi;
          w_lo <= step_lo;
          if (cnt == LAST) begin
            // HI/LO change only on the op's final edge, never mid-operation.
            if (!use_fix) begin
              hi_q <= step_hi;
              lo_q <= step_lo;
            end
          end else begin
            cnt <= cnt + CNTB'(1);
          end
        end
        ST_FIX: begin
`ifdef SIGNED_MDU_EN
          if (is_div_q) begin
            lo_q <= neg_q ? bus.i_alu_result : w_lo;
            hi_q <= neg_rem_q ? -w_hi : w_hi;
          end else if (!fix_step_q) begin
            w_lo       <= neg_q ? bus.i_alu_result : w_lo;
            borrow_q   <= neg_q & (w_lo != '0);
            fix_step_q <= 1'b1;
          end else begin
            hi_q <= neg_q ? bus.i_alu_result : w_hi;
            lo_q <= w_lo;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.o_alu_sel       = (state == ST_RUN) || (state == ST_FIX);
  assign bus.o_alu_data_1    = alu_a;
  assign bus.o_alu_data_2    = alu_b;
  assign bus.o_alu_operation = alu_op;
  assign bus.o_alu_ushamt    = 1'b0;
  assign bus.o_alu_shamt     = 5'd0;
  assign bus.o_ready         = (state == ST_IDLE);
  assign bus.o_done          = (state == ST_DONE);
  assign bus.o_hi            = hi_q;
  assign bus.o_lo            = lo_q;

endmodule
